// File: rtl/adsr_envelope.sv
// Linear ADSR envelope generator driven by a sample-rate tick strobe.
// Define ADSR_EXP_RELEASE_EN for an approximately exponential release tail.
module adsr_envelope #(
  parameter int W         = 12,
  parameter int EXP_SHIFT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         gate,
  input  logic [W-1:0] attack_rate,
  input  logic [W-1:0] decay_rate,
  input  logic [W-1:0] sustain_level,
  input  logic [W-1:0] release_rate,
  output logic [W-1:0] env,
  output logic [2:0]   stage,
  output logic         active,
  output logic         env_tick
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_t;

`ifdef ADSR_EXP_RELEASE_EN
  localparam bit EXP_REL = 1'b1;
`else
  localparam bit EXP_REL = 1'b0;
`endif

  localparam logic [W:0] MAX_EXT = {1'b0, {W{1'b1}}};

  stage_t       state, state_nxt;
  logic [W-1:0] env_q, env_nxt;
  logic         env_tick_q, env_tick_nxt;
  logic         gate_d;
  logic         armed;
  logic         rise, fall;

  logic [W:0]   att_sum;
  logic [W:0]   dec_step;
  logic [W:0]   dec_floor;
  logic [W:0]   rel_step;

  // A zero rate still moves by one LSB, so the envelope never stalls.
  function automatic logic [W:0] step_of(input logic [W-1:0] rate);
    return {1'b0, rate} + {{W{1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] sat_max(input logic [W:0] sum);
    return (sum >= MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] level,
                                           input logic [W:0]   step);
    logic [W:0] diff;
    diff = {1'b0, level} - step;
    return ({1'b0, level} <= step) ? '0 : diff[W-1:0];
  endfunction

  assign att_sum   = {1'b0, env_q} + step_of(attack_rate);
  assign dec_step  = step_of(decay_rate);
  assign dec_floor = {1'b0, sustain_level} + dec_step;
  assign rel_step  = EXP_REL ? (({1'b0, env_q} >> EXP_SHIFT) + step_of(release_rate))
                             : step_of(release_rate);

  // A gate already high when reset lifts must be seen low before it can retrigger.
  assign rise = gate & ~gate_d & armed;
  assign fall = ~gate & gate_d;

  always_comb begin
    state_nxt    = state;
    env_nxt      = env_q;
    env_tick_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ATTACK;
        end else if (tick) begin
          env_nxt      = '0;
          env_tick_nxt = 1'b1;
        end
      end
      ATTACK: begin
        if (fall) begin
          state_nxt = RELEASE;
        end else if (tick) begin
          env_nxt      = sat_max(att_sum);
          env_tick_nxt = 1'b1;
          if (att_sum >= MAX_EXT) state_nxt = DECAY;
        end
      end
      DECAY: begin
        if (fall) begin
          state_nxt = RELEASE;
        end else if (tick) begin
          env_tick_nxt = 1'b1;
          if ({1'b0, env_q} <= dec_floor) begin
            env_nxt   = sustain_level;
            state_nxt = SUSTAIN;
          end else begin
            env_nxt = sat_sub(env_q, dec_step);
          end
        end
      end
      SUSTAIN: begin
        if (fall) begin
          state_nxt = RELEASE;
        end else if (tick) begin
          env_nxt      = sustain_level;
          env_tick_nxt = 1'b1;
        end
      end
      RELEASE: begin
        if (rise) begin
          state_nxt = ATTACK;
        end else if (tick) begin
          env_nxt      = sat_sub(env_q, rel_step);
          env_tick_nxt = 1'b1;
          if ({1'b0, env_q} <= rel_step) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        env_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      env_q      <= '0;
      env_tick_q <= 1'b0;
      gate_d     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      env_q      <= env_nxt;
      env_tick_q <= env_tick_nxt;
      gate_d     <= gate;
      armed      <= armed | ~gate;
    end
  end

  assign env      = env_q;
  assign stage    = state;
  assign active   = (state != IDLE);
  assign env_tick = env_tick_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope shapes plus a
// randomized run against an integer reference model of the envelope rules.
module tb_adsr_envelope;

  localparam int W         = 12;
  localparam int MAX       = 4095;
  localparam int EXP_SHIFT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          gate;
  logic [W-1:0]  attack_rate, decay_rate, sustain_level, release_rate;
  logic [W-1:0]  env;
  logic [2:0]    stage;
  logic          active;
  logic          env_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (plain integers)
  int m_env, m_stage, m_etick;
  bit m_gd, m_seen_low;

  adsr_envelope #(.W(W), .EXP_SHIFT(EXP_SHIFT)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .env(env), .stage(stage), .active(active), .env_tick(env_tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_env = 0; m_stage = 0; m_etick = 0; m_gd = 0; m_seen_low = 0;
  endtask

  task automatic model_step();
    bit rise, fall, moved;
    int s;
    rise  = gate && !m_gd && m_seen_low;
    fall  = !gate && m_gd;
    moved = 0;
    m_etick = 0;
    if (rise && (m_stage == 0 || m_stage == 4)) begin
      m_stage = 1; moved = 1;
    end else if (fall && m_stage >= 1 && m_stage <= 3) begin
      m_stage = 4; moved = 1;
    end
    if (!moved && tick) begin
      m_etick = 1;
      case (m_stage)
        0: m_env = 0;
        1: begin
          s = int'(attack_rate) + 1;
          if (m_env + s >= MAX) begin m_env = MAX; m_stage = 2; end
          else m_env = m_env + s;
        end
        2: begin
          s = int'(decay_rate) + 1;
          if (m_env <= int'(sustain_level) + s) begin m_env = int'(sustain_level); m_stage = 3; end
          else m_env = m_env - s;
        end
        3: m_env = int'(sustain_level);
        default: begin
          s = int'(release_rate) + 1;
`ifdef ADSR_EXP_RELEASE_EN
          s = s + (m_env / (1 << EXP_SHIFT));
`endif
          if (m_env <= s) begin m_env = 0; m_stage = 0; end
          else m_env = m_env - s;
        end
      endcase
    end
    m_gd = gate;
    if (!gate) m_seen_low = 1;
  endtask

  // One clock: apply tick, advance DUT and model, settle outputs.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 0; gate = 0;
    attack_rate = 0; decay_rate = 0; sustain_level = 0; release_rate = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (env !== 12'd0 || stage !== 3'd0 || active !== 1'b0 || env_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: env=%0d stage=%0d active=%0b env_tick=%0b, required 0/0/0/0",
               env, stage, active, env_tick);
    end
    reset_n = 1'b1;
    repeat (2) cyc(0);
  endtask

  task automatic test_attack_decay();
    int att[4] = '{1024, 2048, 3072, 4095};
    int dec[9] = '{3839, 3583, 3327, 3071, 2815, 2559, 2303, 2047, 2000};
    int want_stage;
    attack_rate = 12'd1023; decay_rate = 12'd255;
    sustain_level = 12'd2000; release_rate = 12'd499;
    gate = 1'b1;
    cyc(0);
    n_cmp++;
    if (stage !== 3'd1 || env !== 12'd0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_to_attack: stage=%0d env=%0d active=%0b, required 1/0/1", stage, env, active);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (9) cyc(0);
      cyc(1);
      want_stage = (i == 3) ? 2 : 1;
      n_cmp++;
      if (env !== 12'(att[i]) || stage !== 3'(want_stage) || env_tick !== 1'b1) begin
        n_fail++;
        $display("FAIL attack_step%0d: env=%0d stage=%0d env_tick=%0b, required %0d/%0d/1",
                 i, env, stage, env_tick, att[i], want_stage);
      end
    end
    cyc(0);
    n_cmp++;
    if (env_tick !== 1'b0 || env !== 12'd4095) begin
      n_fail++;
      $display("FAIL env_tick_pulse: env_tick=%0b env=%0d, required 0/4095", env_tick, env);
    end
    for (int i = 0; i < 9; i++) begin
      repeat (9) cyc(0);
      cyc(1);
      want_stage = (i == 8) ? 3 : 2;
      n_cmp++;
      if (env !== 12'(dec[i]) || stage !== 3'(want_stage)) begin
        n_fail++;
        $display("FAIL decay_step%0d: env=%0d stage=%0d, required %0d/%0d",
                 i, env, stage, dec[i], want_stage);
      end
    end
  endtask

  task automatic test_sustain_track();
    sustain_level = 12'd1500;
    repeat (5) cyc(0);
    n_cmp++;
    if (env !== 12'd2000) begin
      n_fail++;
      $display("FAIL sustain_hold_no_tick: env=%0d, required 2000", env);
    end
    cyc(1);
    n_cmp++;
    if (env !== 12'd1500 || stage !== 3'd3) begin
      n_fail++;
      $display("FAIL sustain_track: env=%0d stage=%0d, required 1500/3", env, stage);
    end
  endtask

  task automatic test_release();
    int rel[3] = '{1000, 500, 0};
    int rst[3] = '{4, 4, 0};
    release_rate = 12'd499;
    gate = 1'b0;
    cyc(0);
    n_cmp++;
    if (stage !== 3'd4 || env !== 12'd1500 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_to_release: stage=%0d env=%0d active=%0b, required 4/1500/1", stage, env, active);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (9) cyc(0);
      cyc(1);
      n_cmp++;
      if (env !== 12'(rel[i]) || stage !== 3'(rst[i]) || active !== (rst[i] != 0)) begin
        n_fail++;
        $display("FAIL release_step%0d: env=%0d stage=%0d active=%0b, required %0d/%0d",
                 i, env, stage, active, rel[i], rst[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    gate = 1'b1;
    cyc(0);
    attack_rate = 12'd999;
    cyc(1);
    gate = 1'b0;
    cyc(0);
    n_cmp++;
    if (stage !== 3'd4 || env !== 12'd1000) begin
      n_fail++;
      $display("FAIL retrig_setup: stage=%0d env=%0d, required 4/1000", stage, env);
    end
    gate = 1'b1;
    cyc(1);
    n_cmp++;
    if (stage !== 3'd1 || env !== 12'd1000 || env_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL retrig_edge_wins: stage=%0d env=%0d env_tick=%0b, required 1/1000/0",
               stage, env, env_tick);
    end
    attack_rate = 12'd99;
    repeat (3) cyc(0);
    cyc(1);
    n_cmp++;
    if (env !== 12'd1100 || stage !== 3'd1) begin
      n_fail++;
      $display("FAIL retrig_attack: env=%0d stage=%0d, required 1100/1", env, stage);
    end
  endtask

  task automatic test_sustain_max();
    sustain_level = 12'd4095;
    attack_rate   = 12'd4095;
    cyc(1);
    n_cmp++;
    if (env !== 12'd4095 || stage !== 3'd2) begin
      n_fail++;
      $display("FAIL attack_saturate: env=%0d stage=%0d, required 4095/2", env, stage);
    end
    cyc(1);
    n_cmp++;
    if (env !== 12'd4095 || stage !== 3'd3) begin
      n_fail++;
      $display("FAIL decay_sus_max: env=%0d stage=%0d, required 4095/3", env, stage);
    end
  endtask

  task automatic test_release_shape();
`ifdef ADSR_EXP_RELEASE_EN
    int want[2] = '{3839, 3599};
`else
    int want[2] = '{4094, 4093};
`endif
    release_rate = 12'd0;
    gate = 1'b0;
    cyc(0);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      n_cmp++;
      if (env !== 12'(want[i]) || stage !== 3'd4) begin
        n_fail++;
        $display("FAIL release_shape%0d: env=%0d stage=%0d, required %0d/4", i, env, stage, want[i]);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_rate();
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 4095));
    return W'($urandom_range(0, 400));
  endfunction

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: attack_rate   = rand_rate();
          1: decay_rate    = rand_rate();
          2: sustain_level = W'($urandom_range(0, 4095));
          default: release_rate = rand_rate();
        endcase
      end
      cyc(logic'($urandom_range(0, 3) == 0));
      n_cmp++;
      if (env !== m_env[W-1:0] || stage !== m_stage[2:0] ||
          active !== (m_stage != 0) || env_tick !== m_etick[0]) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: env=%0d stage=%0d active=%0b env_tick=%0b, required %0d/%0d/%0b/%0d",
                   c, env, stage, active, env_tick, m_env, m_stage, (m_stage != 0), m_etick);
      end
    end
  endtask

  task automatic test_async_reset();
    gate = 1'b0; release_rate = 12'd4095;
    repeat (3) cyc(1);
    gate = 1'b1; attack_rate = 12'd1023;
    cyc(0);
    cyc(1);
    cyc(1);
    n_cmp++;
    if (env !== 12'd2048 || stage !== 3'd1 || env_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: env=%0d stage=%0d env_tick=%0b, required 2048/1/1", env, stage, env_tick);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (env !== 12'd0 || stage !== 3'd0 || active !== 1'b0 || env_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: env=%0d stage=%0d active=%0b env_tick=%0b, required 0/0/0/0",
               env, stage, active, env_tick);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cyc(1);
    n_cmp++;
    if (stage !== 3'd0 || env !== 12'd0) begin
      n_fail++;
      $display("FAIL held_gate_no_rise: stage=%0d env=%0d, required 0/0", stage, env);
    end
    gate = 1'b0;
    cyc(0);
    gate = 1'b1;
    cyc(0);
    n_cmp++;
    if (stage !== 3'd1 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_rise: stage=%0d active=%0b, required 1/1", stage, active);
    end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_sustain_track();
    test_release();
    test_retrigger();
    test_sustain_max();
    test_release_shape();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
